// File: rtl/ioexp_spi_pkg.sv
// Shared types and defaults for the I/O-expander SPI master.
package ioexp_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StDone
    } state_e;

    localparam int unsigned DEF_OUTBITS     = 7;
    localparam int unsigned DEF_INBITS      = 3;
    localparam int unsigned DEF_HALF_DIV    = 4;
    localparam int unsigned DEF_CE_SETUP    = 4;
    localparam int unsigned DEF_CE_HOLD     = 4;
    localparam int unsigned DEF_POLL_PERIOD = 1024;

    // Frame length covers whichever of the two words is wider.
    function automatic int unsigned nbits(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ioexp_sclk_tick.sv
// Loadable down-counter; tick is high while the count sits at zero.
module ioexp_sclk_tick #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/ioexp_spi_master.sv
// SPI master for the 3-in/7-out I/O expander: shifts tx_data out MSB first, captures inputs.
// Optional IOEXP_AUTOPOLL_EN: re-sends the last accepted word every POLL_PERIOD idle cycles.
module ioexp_spi_master
    import ioexp_spi_pkg::*;
#(
    parameter int unsigned OUTBITS  = DEF_OUTBITS,
    parameter int unsigned INBITS   = DEF_INBITS,
    parameter int unsigned HALF_DIV = DEF_HALF_DIV,
    parameter int unsigned CE_SETUP = DEF_CE_SETUP,
    parameter int unsigned CE_HOLD  = DEF_CE_HOLD
`ifdef IOEXP_AUTOPOLL_EN
    ,
    parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OUTBITS-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [INBITS-1:0]  rx_data,
    output logic               sclk,
    output logic               ce_n,
    output logic               sin,
    input  logic               sout
);

    localparam int unsigned NBITS = nbits(OUTBITS, INBITS);
    localparam int unsigned BCW   = $clog2(NBITS + 1);
    localparam int unsigned CNTW  = 16;

    state_e              state_q, state_d;
    logic                cnt_load;
    logic [CNTW-1:0]     cnt_val;
    logic                tick;
    logic                go;
    logic [OUTBITS-1:0]  tx_src;
    logic [NBITS-1:0]    tx_load;
    logic [NBITS-1:0]    tx_sr;
    logic [INBITS-1:0]   rx_sr;
    logic [BCW-1:0]      bit_cnt;

`ifdef IOEXP_AUTOPOLL_EN
    localparam int unsigned PCW = $clog2(POLL_PERIOD + 1);
    logic [PCW-1:0]     poll_cnt;
    logic [OUTBITS-1:0] last_tx;
    logic               poll_hit;

    assign poll_hit = (state_q == StIdle) && (poll_cnt == PCW'(POLL_PERIOD - 1));
    assign go       = start | poll_hit;
    assign tx_src   = start ? tx_data : last_tx;

    // Counts idle cycles only; an explicit start wins over a poll on the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
            last_tx  <= '0;
        end else begin
            if (state_q == StIdle && start) last_tx <= tx_data;
            if (state_q == StDone) begin
                poll_cnt <= '0;
            end else if (state_q == StIdle && !poll_hit) begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end
`else
    assign go     = start;
    assign tx_src = tx_data;
`endif

    assign tx_load = NBITS'(tx_src);

    ioexp_sclk_tick #(
        .W (CNTW)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            StIdle: if (go) begin
                state_d  = StSetup;
                cnt_load = 1'b1;
                cnt_val  = CNTW'(CE_SETUP - 1);
            end
            StSetup, StLow: if (tick) begin
                state_d  = (state_q == StSetup) ? StLow : StHigh;
                cnt_load = 1'b1;
                cnt_val  = CNTW'(HALF_DIV - 1);
            end
            StHigh: if (tick) begin
                cnt_load = 1'b1;
                if (bit_cnt == BCW'(NBITS)) begin
                    state_d = StHold;
                    cnt_val = CNTW'(CE_HOLD - 1);
                end else begin
                    state_d = StLow;
                    cnt_val = CNTW'(HALF_DIV - 1);
                end
            end
            StHold:  if (tick) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pin outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sclk    <= 1'b1;
            ce_n    <= 1'b1;
            sin     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            sclk    <= (state_d != StLow);
            ce_n    <= !(state_d inside {StSetup, StLow, StHigh, StHold});
            busy    <= (state_d != StIdle);
            done    <= (state_d == StDone);
            if (state_q == StIdle && go) begin
                tx_sr   <= tx_load;
                sin     <= tx_load[NBITS-1];
                rx_sr   <= '0;
                bit_cnt <= '0;
            end
            // Sample on the falling SCLK edge; expander updates sout on the rise.
            if (state_q != StLow && state_d == StLow) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt < BCW'(INBITS)) rx_sr <= {sout, rx_sr[INBITS-1:1]};
            end
            if (state_q == StLow && state_d == StHigh) begin
                tx_sr <= tx_sr << 1;
                sin   <= tx_sr[NBITS-2];
            end
            if (state_d == StDone) rx_data <= rx_sr;
        end
    end

endmodule
